mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_pkg.sv | 11 +
 rtl/mult_arbiter_pipe.sv | 45 ++++
 rtl/mult_arbiter.sv | 142 ++++++++++++++
 tb/tb_mult_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: shared FSM state type, default parameters and id-width helper.
package mult_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_MULT_LATENCY = 3;
  localparam int DEF_FIFO_DEPTH   = 8;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mult_arbiter_pipe.sv
// mult_pipe: tagged unsigned multiplier, product and id delayed MULT_LATENCY cycles.
module mult_pipe
  import mult_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int ID_W         = id_w(DEF_NUM_REQ)
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic [ID_W-1:0]         in_id,
  output logic                    out_valid,
  output logic [ID_W-1:0]         out_id,
  output logic [2*DATA_WIDTH-1:0] out_product
);
  localparam int PW = 2 * DATA_WIDTH;
  logic [MULT_LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]           prod_q [MULT_LATENCY];
  logic [PW-1:0]           prod_d [MULT_LATENCY];
  logic [ID_W-1:0]         id_q   [MULT_LATENCY];
  logic [ID_W-1:0]         id_d   [MULT_LATENCY];
  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_valid;
    prod_d[0] = PW'(in_a) * PW'(in_b);
    id_d[0]   = in_id;
    for (int i = 1; i < MULT_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      prod_d[i] = prod_q[i-1];
      id_d[i]   = id_q[i-1];
    end
  end
  always_ff @(posedge ACLK) vld_q <= ARESET ? '0 : vld_d;
  // Data stages carry no reset; only the valid bits qualify them.
  always_ff @(posedge ACLK) begin
    prod_q <= prod_d;
    id_q   <= id_d;
  end
  assign out_valid   = vld_q[MULT_LATENCY-1];
  assign out_id      = id_q[MULT_LATENCY-1];
  assign out_product = prod_q[MULT_LATENCY-1];
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one pipelined multiplier with credit-guarded result FIFO.
// Optional MULT_ARBITER_STATS_EN adds per-requester saturating transfer counters on grant_cnt.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          cfg_enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [id_w(NUM_REQ)-1:0]      rsp_id,
  output logic [2*DATA_WIDTH-1:0]       rsp_product,
  output logic                          busy
`ifdef MULT_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);
  localparam int ID_W = id_w(NUM_REQ);
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int AW   = id_w(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  state_e                state_q, state_d;
  logic [ID_W-1:0]       rr_q, rr_d, gnt_idx, cand;
  logic                  gnt_ok, grant_en, credit, xfer, push, pop;
  logic [DATA_WIDTH-1:0] a_sel, b_sel;
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d, infl_q, infl_d;
  logic [CW:0]           used;
  logic [ID_W-1:0]       pipe_id;
  logic [PW-1:0]         pipe_prod;
  logic [ID_W-1:0]       mem_id   [FIFO_DEPTH];
  logic [PW-1:0]         mem_prod [FIFO_DEPTH];
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge ACLK) state_q <= ARESET ? IDLE : state_d;
  always_comb state_d = cfg_enable ? ACTIVE :
                        (state_q == ACTIVE || (state_q == DRAIN && busy)) ? DRAIN : IDLE;
  // A credit is every slot not already claimed by an in-flight product or a queued result.
  always_comb begin
    used     = {1'b0, infl_q} + {1'b0, cnt_q};
    credit   = used < (CW+1)'(FIFO_DEPTH);
    grant_en = state_q == ACTIVE && credit;
  end
  always_comb begin
    gnt_idx = '0;
    gnt_ok  = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt_idx = cand;
        gnt_ok  = 1'b1;
      end
    end
    req_ready = (grant_en && gnt_ok) ? NUM_REQ'(1'b1) << gnt_idx : '0;
    xfer      = |req_ready;
    rr_d      = xfer ? gnt_idx : rr_q;
  end
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        a_sel = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  mult_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MULT_LATENCY(MULT_LATENCY),
    .ID_W        (ID_W)
  ) u_pipe (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .in_valid   (xfer),
    .in_a       (a_sel),
    .in_b       (b_sel),
    .in_id      (gnt_idx),
    .out_valid  (push),
    .out_id     (pipe_id),
    .out_product(pipe_prod)
  );
  always_comb begin
    pop    = rsp_valid && rsp_ready;
    wr_d   = push ? inc(wr_q) : wr_q;
    rd_d   = pop ? inc(rd_q) : rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    infl_d = infl_q + CW'(xfer) - CW'(push);
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_q   <= ID_W'(NUM_REQ - 1);
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
    end else begin
      rr_q   <= rr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
    end
  end
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_id[wr_q]   <= pipe_id;
      mem_prod[wr_q] <= pipe_prod;
    end
  end
  assign rsp_valid   = cnt_q != '0;
  assign rsp_id      = mem_id[rd_q];
  assign rsp_product = mem_prod[rd_q];
  assign busy        = infl_q != '0 || cnt_q != '0;
`ifdef MULT_ARBITER_STATS_EN
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] gcnt_d [NUM_REQ];
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gcnt_d[i] = (req_ready[i] && gcnt_q[i] != 16'hFFFF) ? gcnt_q[i] + 16'd1 : gcnt_q[i];
      grant_cnt[i*16 +: 16] = gcnt_q[i];
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) gcnt_q <= '{default: '0};
    else gcnt_q <= gcnt_d;
  end
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed plus random stimulus checked against a transaction-level model.
module tb_mult_arbiter;
  localparam int N = 4, DW = 32, L = 3, D = 8;
  logic            ACLK = 1'b0, ARESET = 1'b1, cfg_enable = 1'b0, rsp_ready = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0, req_b = '0;
  logic            rsp_valid, busy;
  logic [1:0]      rsp_id;
  logic [2*DW-1:0] rsp_product;
`ifdef MULT_ARBITER_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif
  mult_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MULT_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_enable(cfg_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .busy(busy)
`ifdef MULT_ARBITER_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );
  always #5 ACLK = ~ACLK;

  typedef struct {int id; logic [63:0] p; int rdy;} item_t;
  item_t        q[$];
  int           n_chk = 0, n_fail = 0, cyc = 0, last_m = N - 1, exp_g;
  int           dut_gnt = 0, dut_rsp = 0, dut_rv = 0, obs_c, t0, g0, r0, rv0;
  logic         active_m = 1'b0, exp_rv, obs_rv, obs_busy;
  logic [N-1:0] exp_rdy, obs_rdy;
  logic [1:0]   obs_id;
  logic [63:0]  obs_prod;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    if (!active_m || q.size() >= D) return -1;
    for (int k = 1; k <= N; k++)
      if (req_valid[(last_m + k) % N]) return (last_m + k) % N;
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic step();
    @(negedge ACLK);
    exp_g   = pick();
    exp_rdy = (exp_g >= 0) ? N'(1) << exp_g : '0;
    exp_rv  = q.size() > 0 && cyc >= q[0].rdy;
    obs_c = cyc; obs_rdy = req_ready; obs_rv = rsp_valid; obs_busy = busy;
    obs_id = rsp_id; obs_prod = rsp_product;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_product", rsp_product, q[0].p);
    end
    chk("busy", 64'(busy), 64'(q.size() != 0));
    if (|(req_ready & req_valid)) dut_gnt++;
    if (rsp_valid) dut_rv++;
    if (rsp_valid && rsp_ready) dut_rsp++;
    @(posedge ACLK);
    if (ARESET) begin
      q.delete();
      active_m = 1'b0;
      last_m   = N - 1;
    end else begin
      if (exp_rv && rsp_ready) void'(q.pop_front());
      if (exp_g >= 0) begin
        q.push_back('{id: exp_g, rdy: cyc + L + 1,
                      p: 64'(req_a[exp_g*DW +: DW]) * 64'(req_b[exp_g*DW +: DW])});
        last_m = exp_g;
      end
      active_m = cfg_enable;
    end
    cyc++;
    #1;
  endtask

  task automatic wait_rsp();
    int t = 0;
    do step(); while (!obs_rv && ++t < 20);
  endtask

  task automatic drain_wait(input string tag);
    int t = 0;
    do step(); while (obs_busy && ++t < 200);
    chk(tag, 64'(obs_busy), 64'(0));
  endtask

  initial begin
    cfg_enable = 1'b1;
    req_valid  = '1;
    @(posedge ACLK);
    #1;
    step();
    chk("reset_ready", 64'(obs_rdy), 64'(0));
    ARESET = 1'b0; req_valid = '0;
    step();
    set_op(2, 32'h7, 32'h6);
    req_valid = 4'b0100; t0 = cyc;
    step();
    chk("single_grant", 64'(obs_rdy), 64'(4'b0100));
    req_valid = '0; rsp_ready = 1'b1;
    wait_rsp();
    chk("single_lat", 64'(obs_c - t0), 64'(4));
    chk("single_id", 64'(obs_id), 64'(2));
    chk("single_prod", obs_prod, 64'h2A);
    drain_wait("single_idle");
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    step();
    req_valid = '1; g0 = dut_gnt;
    step();
    chk("fair_first", 64'(obs_rdy), 64'(4'b0001));
    repeat (7) step();
    chk("fair_cnt", 64'(dut_gnt - g0), 64'(8));
    chk("fair_last", 64'(obs_rdy), 64'(4'b1000));
    req_valid = '0;
    drain_wait("fair_idle");
    rsp_ready = 1'b0; req_valid = '1; g0 = dut_gnt;
    repeat (14) step();
    chk("bp_cnt", 64'(dut_gnt - g0), 64'(8));
    chk("bp_ready", 64'(obs_rdy), 64'(0));
    req_valid = '0; rsp_ready = 1'b1; r0 = dut_rsp;
    drain_wait("bp_idle");
    chk("bp_rsp", 64'(dut_rsp - r0), 64'(8));
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    wait_rsp();
    chk("wide_id", 64'(obs_id), 64'(1));
    chk("wide_prod", obs_prod, 64'hFFFF_FFFE_0000_0001);
    drain_wait("wide_idle");
    req_valid = '1; r0 = dut_rsp;
    repeat (3) step();
    cfg_enable = 1'b0; req_valid = '0;
    step();
    req_valid = '1; g0 = dut_gnt;
    drain_wait("drain_idle");
    chk("drain_gnt", 64'(dut_gnt - g0), 64'(0));
    chk("drain_rsp", 64'(dut_rsp - r0), 64'(3));
    cfg_enable = 1'b1; req_valid = '0;
    step();
    req_valid = 4'b1100;
    repeat (2) step();
    req_valid = '0; ARESET = 1'b1; rv0 = dut_rv;
    step();
    ARESET = 1'b0;
    repeat (8) step();
    chk("rst_no_rsp", 64'(dut_rv - rv0), 64'(0));
    req_valid = '1;
    step();
    chk("rst_first", 64'(obs_rdy), 64'(4'b0001));
    req_valid = '0;
    drain_wait("rst_idle");
    for (int i = 0; i < 1500; i++) begin
      req_valid = N'($urandom);
      req_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_b = {$urandom(), $urandom(), $urandom(), $urandom()};
      rsp_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 19) == 0) cfg_enable = ~cfg_enable;
      ARESET = $urandom_range(0, 99) == 0;
      step();
    end
    ARESET = 1'b0; cfg_enable = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    drain_wait("final_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
